vr_pipe_buffer: RTL and testbench
=================================

VR_PIPE_BUFFER -- requirements
Module: vr_pipe_buffer

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of storage entries (power of 2, >=2).
REQ-003 Parameter AFULL_LVL, default DEPTH-1, occupancy at or above which almost_full asserts (1..DEPTH).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 valid_in  input  1  producer data valid.
REQ-008 data_in  input  WIDTH  producer payload.
REQ-009 ready_in  output  1  buffer can accept a beat this cycle.
REQ-010 valid_out  output  1  buffer presents a valid beat.
REQ-011 data_out  output  WIDTH  payload of oldest entry.
REQ-012 ready_out  input  1  consumer accepts beat.
REQ-013 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-014 almost_full  output  1  count >= AFULL_LVL.

Function
REQ-015 Push = valid_in && ready_in; pop = valid_out && ready_out; both evaluated in the same cycle.
REQ-016 ready_in SHALL be (count < DEPTH), decoded from registered state only; no combinational path from ready_out to ready_in.
REQ-017 valid_out SHALL be (count != 0); data_out SHALL be mem[rd_ptr]; no combinational path from valid_in/data_in to any output.
REQ-018 Latency: a beat pushed at edge N SHALL be visible on data_out/valid_out after edge N (earliest pop cycle N+1); no fall-through.
REQ-019 Order: beats SHALL leave in exactly the order accepted, with payload unmodified.
REQ-020 Push only: mem[wr_ptr] <= data_in, wr_ptr +1 modulo DEPTH, count +1.
REQ-021 Pop only: rd_ptr +1 modulo DEPTH, count -1.
REQ-022 Push and pop same cycle (0 < count < DEPTH): both pointers advance, count unchanged.
REQ-023 Full (count == DEPTH): ready_in low even if ready_out high; a pop that cycle frees an entry and ready_in rises next cycle.
REQ-024 Empty (count == 0): valid_out low; a push and no pop.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL be seamless with no bubble.
REQ-026 flush SHALL take priority: count, wr_ptr, rd_ptr <= 0; any concurrent push is dropped and any concurrent pop is void; mem contents unchanged.
REQ-027 valid_out SHALL hold high and data_out stable while ready_out is low (no retraction).
REQ-028 Back-to-back throughput of one beat per cycle SHALL be sustained whenever 0 < count < DEPTH.

Reset
REQ-029 On rst assertion: count=0, wr_ptr=0, rd_ptr=0, valid_out=0, ready_in=1, almost_full=0 (AFULL_LVL>=1), immediately and independent of clk.
REQ-030 Storage array SHALL NOT be reset; data_out is don't-care while valid_out is low.
REQ-031 Reset asserted mid-transfer SHALL discard all entries; first valid_out after release only follows a new push.

Structure
REQ-032 Shared package vr_pkg SHALL hold default WIDTH/DEPTH constants and the pointer/count width helper function.
REQ-033 Storage array SHALL be a single sub-module vr_buf_mem (one write port, one async read port, no reset).
REQ-034 Control (pointers, count, flags) SHALL reside in vr_pipe_buffer itself.

Verification (WIDTH=8, DEPTH=4, AFULL_LVL=3)
REQ-035 After reset, push 0x11,0x22,0x33 with ready_out=0 -> count=3, almost_full=1, ready_in=1, data_out=0x11.
REQ-036 Push 0x44 then hold valid_in with 0x55, ready_out=0 -> count=4, ready_in=0, 0x55 not accepted; raise ready_out one cycle -> 0x11 popped, ready_in=1 next cycle.
REQ-037 Continuous valid_in and ready_out=1 for 12 beats 0x00..0x0B -> outputs 0x00..0x0B in order, one per cycle after first, pointers wrap 3 times, count stays 1.
REQ-038 count=2, assert flush with valid_in=1 (0x99) and ready_out=1 -> next cycle count=0, valid_out=0, 0x99 never emitted.
REQ-039 count=3, assert rst asynchronously mid-cycle -> valid_out=0, count=0, ready_in=1 before next clk edge; post-release first output is next pushed beat.
REQ-040 Random valid_in/ready_out (50%) over 1000 cycles vs reference queue -> zero order/data mismatches, no push when ready_in=0 accepted.

Source files
------------

// File: rtl/vr_pkg.sv
// Shared constants and width helpers for the valid/ready pipe buffer.
package vr_pkg;

   localparam int VR_WIDTH = 8;
   localparam int VR_DEPTH = 4;

   // Pointer width for a power-of-2 depth; never narrower than one bit.
   function automatic int vr_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy counter has to represent 0..depth inclusive.
   function automatic int vr_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/vr_buf_mem.sv
// Entry storage for the pipe buffer: one synchronous write port, one async read port.
module vr_buf_mem
   import vr_pkg::*;
#(
   parameter int WIDTH = VR_WIDTH,
   parameter int DEPTH = VR_DEPTH,
   parameter int AW    = vr_ptr_w(VR_DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   // Deliberately unreset: contents only matter behind a valid count.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/vr_pipe_buffer.sv
// Valid/ready FIFO buffer: registered occupancy, no fall-through, flush has priority.
module vr_pipe_buffer
   import vr_pkg::*;
#(
   parameter int WIDTH     = VR_WIDTH,
   parameter int DEPTH     = VR_DEPTH,
   parameter int AFULL_LVL = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       valid_in,
   input  logic [WIDTH-1:0]           data_in,
   output logic                       ready_in,
   output logic                       valid_out,
   output logic [WIDTH-1:0]           data_out,
   input  logic                       ready_out,
   output logic [vr_cnt_w(DEPTH)-1:0] count,
   output logic                       almost_full
);

   localparam int PW = vr_ptr_w(DEPTH);
   localparam int CW = vr_cnt_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          push;
   logic          pop;
   logic          mem_we;

   // Handshake flags come only from count_q, so ready_out never reaches ready_in.
   assign ready_in    = (count_q < DEPTH_C);
   assign valid_out   = (count_q != '0);
   assign almost_full = (count_q >= AFULL_C);
   assign count       = count_q;

   assign push   = valid_in && ready_in;
   assign pop    = valid_out && ready_out;
   assign mem_we = push && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Power-of-2 depth lets the pointers wrap by plain overflow.
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   vr_buf_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (data_out)
   );

endmodule

// File: tb/tb_vr_pipe_buffer.sv
// Directed-vector and reference-queue bench for vr_pipe_buffer (WIDTH=8, DEPTH=4, AFULL_LVL=3).
module tb_vr_pipe_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       valid_in;
   logic [7:0] data_in;
   logic       ready_in;
   logic       valid_out;
   logic [7:0] data_out;
   logic       ready_out;
   logic [2:0] count;
   logic       almost_full;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vr_pipe_buffer #(.WIDTH(8), .DEPTH(4), .AFULL_LVL(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .valid_in    (valid_in),
      .data_in     (data_in),
      .ready_in    (ready_in),
      .valid_out   (valid_out),
      .data_out    (data_out),
      .ready_out   (ready_out),
      .count       (count),
      .almost_full (almost_full)
   );

   typedef struct {
      logic       fl;
      logic       vi;
      logic [7:0] din;
      logic       ro;
      logic [2:0] cnt;
      logic       rin;
      logic       vout;
      logic       af;
      logic [7:0] dout;
   } vec_t;

   vec_t vec [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic [2:0] c, input logic ri,
                            input logic vo, input logic af);
      chk({tag, " count"},       32'(count),       32'(c));
      chk({tag, " ready_in"},    32'(ready_in),    32'(ri));
      chk({tag, " valid_out"},   32'(valid_out),   32'(vo));
      chk({tag, " almost_full"}, 32'(almost_full), 32'(af));
   endtask

   task automatic drive(input logic fl, input logic vi, input logic [7:0] d, input logic ro);
      flush     = fl;
      valid_in  = vi;
      data_in   = d;
      ready_out = ro;
   endtask

   logic [7:0] model_q[$];
   logic       m_push;
   logic       m_pop;
   logic [7:0] r_data;

   initial begin
      //         fl    vi    din    ro    cnt   rin   vout  af    dout
      vec[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h11};
      vec[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h11};
      vec[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 8'h11};
      vec[3]  = '{1'b0, 1'b1, 8'h44, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 8'h11};
      vec[4]  = '{1'b0, 1'b1, 8'h55, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 8'h11};
      vec[5]  = '{1'b0, 1'b1, 8'h55, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 8'h22};
      vec[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 8'h33};
      vec[7]  = '{1'b1, 1'b1, 8'h99, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00};
      vec[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00};
      vec[9]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 8'hA5};
      vec[10] = '{1'b0, 1'b1, 8'h5A, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 8'h5A};
      vec[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h5A};
      vec[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00};

      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      chk_flags("reset", 3'd0, 1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Fill, full back-pressure, single pop, flush, empty push, pass-through.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(vec[i].fl, vec[i].vi, vec[i].din, vec[i].ro);
         @(posedge clk);
         #1;
         chk_flags($sformatf("vec%0d", i), vec[i].cnt, vec[i].rin, vec[i].vout, vec[i].af);
         if (vec[i].vout) chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vec[i].dout));
      end

      // Streaming 12 beats at one per cycle; pointers wrap three times.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 8'(i), 1'b1);
         @(posedge clk);
         #1;
         chk($sformatf("stream%0d count", i), 32'(count), 32'd1);
         chk($sformatf("stream%0d data_out", i), 32'(data_out), 32'(i));
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      @(posedge clk);
      #1;
      chk_flags("stream drain", 3'd0, 1'b1, 1'b0, 1'b0);

      // Async reset mid-cycle with three entries held.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
      end
      @(posedge clk);
      #1;
      chk("pre-rst count", 32'(count), 32'd3);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk_flags("async rst", 3'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      @(posedge clk);
      #1;
      chk("post-rst idle valid_out", 32'(valid_out), 32'd0);
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h77, 1'b0);
      @(posedge clk);
      #1;
      chk("post-rst first data", 32'(data_out), 32'h77);
      chk_flags("post-rst first", 3'd1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      @(posedge clk);

      // Random traffic against a reference queue.
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         chk("rnd count", 32'(count), 32'(model_q.size()));
         chk("rnd ready_in", 32'(ready_in), 32'(model_q.size() < 4));
         chk("rnd valid_out", 32'(valid_out), 32'(model_q.size() != 0));
         if (model_q.size() != 0) chk("rnd data_out", 32'(data_out), 32'(model_q[0]));
         r_data = 8'($urandom);
         drive(1'b0, 1'($urandom_range(0, 1)), r_data, 1'($urandom_range(0, 1)));
         m_push = valid_in && (model_q.size() < 4);
         m_pop  = ready_out && (model_q.size() != 0);
         @(posedge clk);
         if (m_pop)  void'(model_q.pop_front());
         if (m_push) model_q.push_back(r_data);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
